// File: rtl/ula_ar_pkg.sv
// Shared types and constants for the ULA arithmetic sequencer: function codes,
// execution conditions, FSM states and the ULA 5-bit OP encodings.
package ula_ar_pkg;

    typedef enum logic [2:0] {
        F_ADD  = 3'b000,
        F_ADD1 = 3'b001,
        F_INC  = 3'b010,
        F_SUB1 = 3'b011,
        F_SUB  = 3'b100,
        F_DEC  = 3'b101,
        F_ILL6 = 3'b110,
        F_ILL7 = 3'b111
    } funct_e;

    typedef enum logic [2:0] {
        C_ALWAYS = 3'b000,
        C_Z      = 3'b001,
        C_NZ     = 3'b010,
        C_C      = 3'b011,
        C_NC     = 3'b100,
        C_S      = 3'b101,
        C_O      = 3'b110,
        C_NEVER  = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADD1 = 5'b00001;
    localparam logic [4:0] OP_INC  = 5'b00011;
    localparam logic [4:0] OP_SUB1 = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_DEC  = 5'b00110;

    // Returns {legal, op}; illegal codes yield a harmless OP that is never issued.
    function automatic logic [5:0] funct_decode(input logic [2:0] f);
        case (f)
            F_ADD:   funct_decode = {1'b1, OP_ADD};
            F_ADD1:  funct_decode = {1'b1, OP_ADD1};
            F_INC:   funct_decode = {1'b1, OP_INC};
            F_SUB1:  funct_decode = {1'b1, OP_SUB1};
            F_SUB:   funct_decode = {1'b1, OP_SUB};
            F_DEC:   funct_decode = {1'b1, OP_DEC};
            default: funct_decode = {1'b0, OP_ADD};
        endcase
    endfunction

endpackage

// File: rtl/ula_ar_seq_if.sv
// Instruction request / result response handshake bundle between a producer
// (master) and the ULA sequencer (slave).
interface ula_ar_seq_if #(parameter int bits = 8) ();

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct;
    logic [2:0]      cond;
    logic [bits-1:0] ra;
    logic [bits-1:0] rb;
    logic            out_valid;
    logic            out_ready;
    logic [bits-1:0] out_resu;
    logic            out_skip;
    logic            out_err;

    modport master (
        output in_valid, funct, cond, ra, rb, out_ready,
        input  in_ready, out_valid, out_resu, out_skip, out_err
    );

    modport slave (
        input  in_valid, funct, cond, ra, rb, out_ready,
        output in_ready, out_valid, out_resu, out_skip, out_err
    );

endinterface

// File: rtl/ula_ar_cond_eval.sv
// Combinational evaluation of an execution condition against stored flags
// {O,C,S,Z}.
module ula_ar_cond_eval
    import ula_ar_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       take
);

    // Select the flag (or its complement) named by the condition code.
    always_comb begin
        take = 1'b0;
        case (cond)
            C_ALWAYS: take = 1'b1;
            C_Z:      take = flags[0];
            C_NZ:     take = ~flags[0];
            C_C:      take = flags[2];
            C_NC:     take = ~flags[2];
            C_S:      take = flags[1];
            C_O:      take = flags[3];
            C_NEVER:  take = 1'b0;
            default:  take = 1'b0;
        endcase
    end

endmodule

// File: rtl/ula_ar_seq.sv
// Sequencer front-end for the arithmetic ULA: accepts an instruction, issues
// registered operands/OP, captures the result after one settle cycle, updates flags.
module ula_ar_seq
    import ula_ar_pkg::*;
#(
    parameter int bits = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ula_ar_seq_if.slave      bus,
    output logic [bits-1:0]  alu_a,
    output logic [bits-1:0]  alu_b,
    output logic [4:0]       alu_op,
    input  logic [bits-1:0]  alu_resu,
    input  logic             alu_o,
    input  logic             alu_c,
    output logic [3:0]       flags
);

    state_e          state_q, state_d;
    logic [bits-1:0] alu_a_q, alu_a_d;
    logic [bits-1:0] alu_b_q, alu_b_d;
    logic [4:0]      alu_op_q, alu_op_d;
    logic [bits-1:0] out_resu_q, out_resu_d;
    logic            out_valid_q, out_valid_d;
    logic            out_skip_q, out_skip_d;
    logic            out_err_q, out_err_d;
    logic            in_ready_q, in_ready_d;
    logic [3:0]      flags_q, flags_d;
    logic            take_s;
    logic [5:0]      dec_s;

    ula_ar_cond_eval u_cond (
        .cond  (bus.cond),
        .flags (flags_q),
        .take  (take_s)
    );

    assign dec_s = funct_decode(bus.funct);

    // Next-state and next-output computation for the IDLE/EXEC/DONE sequence.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        out_resu_d = out_resu_q;
        out_skip_d = out_skip_q;
        out_err_d  = out_err_q;
        flags_d    = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!dec_s[5]) begin
                        state_d    = DONE;
                        out_err_d  = 1'b1;
                        out_skip_d = 1'b0;
                        out_resu_d = {bits{1'b0}};
                    end else if (!take_s) begin
                        state_d    = DONE;
                        out_skip_d = 1'b1;
                        out_resu_d = bus.ra;
                    end else begin
                        state_d  = EXEC;
                        alu_a_d  = bus.ra;
                        alu_b_d  = bus.rb;
                        alu_op_d = dec_s[4:0];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                // Zero is derived here; the ULA provides no zero flag.
                state_d    = DONE;
                out_resu_d = alu_resu;
                flags_d    = {alu_o, alu_c, alu_resu[bits-1], (alu_resu == {bits{1'b0}})};
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d    = IDLE;
                    out_skip_d = 1'b0;
                    out_err_d  = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= {bits{1'b0}};
            alu_b_q     <= {bits{1'b0}};
            alu_op_q    <= 5'b00000;
            out_resu_q  <= {bits{1'b0}};
            out_valid_q <= 1'b0;
            out_skip_q  <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            out_resu_q  <= out_resu_d;
            out_valid_q <= out_valid_d;
            out_skip_q  <= out_skip_d;
            out_err_q   <= out_err_d;
            in_ready_q  <= in_ready_d;
            flags_q     <= flags_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign flags        = flags_q;
    assign bus.in_ready = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_resu = out_resu_q;
    assign bus.out_skip = out_skip_q;
    assign bus.out_err  = out_err_q;

endmodule
